// File: rtl/minibus_pkg.sv
// Shared minibus transaction types and arbiter FSM state encoding.
package minibus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [3:0]  strobe;
  } minibus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } minibus_res_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int CNT_W = 16;

  // wen together with ren still counts as a single (write) request.
  function automatic logic req_valid(input minibus_req_t r);
    return r.wen | r.ren;
  endfunction

endpackage

// File: rtl/minibus_rr_select.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module minibus_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    idx       = '0;
    any_valid = |valid;
    cand      = 0;
    cand_idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (valid[cand_idx]) idx = cand_idx;
    end
  end

endmodule

// File: rtl/minibus_arbiter.sv
// Round-robin N:1 minibus arbiter with slave-ready timeout; the granted
// master is connected combinationally to the slave side while BUSY.
module minibus_arbiter
  import minibus_pkg::*;
#(
  parameter int MASTER_COUNT   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  minibus_req_t                    m_req [MASTER_COUNT],
  output minibus_res_t                    m_res [MASTER_COUNT],
  output minibus_req_t                    s_req,
  input  minibus_res_t                    s_res,
  output logic [$clog2(MASTER_COUNT)-1:0] grant_idx
);

  localparam int               IDX_W     = $clog2(MASTER_COUNT);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MASTER_COUNT - 1);

  arb_state_t              state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        next_ptr;
  logic [CNT_W-1:0]        tmo_cnt;
  logic [MASTER_COUNT-1:0] valid;
  logic                    any_valid;
  logic                    grant_valid;
  logic                    timeout_fire;
  logic                    done;

  always_comb begin
    for (int i = 0; i < MASTER_COUNT; i++) valid[i] = req_valid(m_req[i]);
  end

  minibus_rr_select #(
    .N     (MASTER_COUNT),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .valid     (valid),
    .rr_ptr    (rr_ptr),
    .idx       (sel_idx),
    .any_valid (any_valid)
  );

  // A granted master that drops its request is treated as an abort.
  assign grant_valid  = (state == BUSY) && valid[grant_idx];
  assign timeout_fire = grant_valid && !s_res.ready && (tmo_cnt == TMO_LIMIT);
  assign done         = (state == BUSY) && (!valid[grant_idx] || s_res.ready || timeout_fire);
  assign next_ptr     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  always_comb begin
    s_req = '0;
    for (int i = 0; i < MASTER_COUNT; i++) m_res[i] = '0;
    if (grant_valid) begin
      if (timeout_fire) begin
        m_res[grant_idx] = '{rdata: '0, ready: 1'b1, error: 1'b1};
      end else begin
        s_req            = m_req[grant_idx];
        m_res[grant_idx] = s_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_idx <= sel_idx;
            tmo_cnt   <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (tmo_cnt != TMO_LIMIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minibus_arbiter.sv
// Directed bench for minibus_arbiter: two masters, timeout limit of 4 cycles.
module tb_minibus_arbiter;
  import minibus_pkg::*;

  logic         clk;
  logic         rst;
  minibus_req_t m_req [2];
  minibus_res_t m_res [2];
  minibus_req_t s_req;
  minibus_res_t s_res;
  logic [0:0]   grant_idx;

  int n_cmp = 0;
  int n_err = 0;

  minibus_arbiter #(
    .MASTER_COUNT   (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_res     (m_res),
    .s_req     (s_req),
    .s_res     (s_res),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic minibus_req_t mk_req(input logic [31:0] addr, input logic [31:0] wdata,
                                          input logic wen, input logic ren);
    minibus_req_t r;
    r.addr   = addr;
    r.wdata  = wdata;
    r.wen    = wen;
    r.ren    = ren;
    r.strobe = 4'hF;
    return r;
  endfunction

  function automatic minibus_res_t mk_res(input logic [31:0] rdata, input logic ready,
                                          input logic error);
    minibus_res_t r;
    r.rdata = rdata;
    r.ready = ready;
    r.error = error;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  minibus_req_t zreq;
  minibus_res_t zres;
  minibus_req_t r0, r1;
  minibus_res_t rs;

  initial begin
    zreq     = '0;
    zres     = '0;
    rst      = 1'b1;
    m_req[0] = '0;
    m_req[1] = '0;
    s_res    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 128'(dut.state), 128'(IDLE));
    chk("rst_grant", 128'(grant_idx), 128'(0));
    chk("rst_sreq", 128'(s_req), 128'(zreq));
    chk("rst_mres0", 128'(m_res[0]), 128'(zres));
    chk("rst_mres1", 128'(m_res[1]), 128'(zres));
    rst = 1'b0;

    // Single master read with two slave wait cycles
    r0 = mk_req(32'h1000, 32'h0, 1'b0, 1'b1);
    m_req[0] = r0;
    #1;
    chk("t1_idle_sreq", 128'(s_req), 128'(zreq));
    step(); #1;
    chk("t1_state", 128'(dut.state), 128'(BUSY));
    chk("t1_grant", 128'(grant_idx), 128'(0));
    chk("t1_sreq", 128'(s_req), 128'(r0));
    chk("t1_wait1_mres0", 128'(m_res[0]), 128'(zres));
    step(); #1;
    chk("t1_wait2_mres0", 128'(m_res[0]), 128'(zres));
    step();
    rs = mk_res(32'hDEADBEEF, 1'b1, 1'b0);
    s_res = rs;
    #1;
    chk("t1_done_mres0", 128'(m_res[0]), 128'(rs));
    chk("t1_done_mres1", 128'(m_res[1]), 128'(zres));
    step();
    m_req[0] = '0;
    #1;
    chk("t1_back_idle", 128'(dut.state), 128'(IDLE));
    chk("t1_idle_mres0", 128'(m_res[0]), 128'(zres));
    chk("t1_rr_ptr", 128'(dut.rr_ptr), 128'(1));
    s_res = '0;

    // Contention from reset, immediate ready: grants alternate
    rst = 1'b1;
    #1;
    chk("t2_rst_rr_ptr", 128'(dut.rr_ptr), 128'(0));
    step();
    rst = 1'b0;
    r0 = mk_req(32'hA000, 32'h11, 1'b1, 1'b0);
    r1 = mk_req(32'hB000, 32'h22, 1'b1, 1'b1);
    m_req[0] = r0;
    m_req[1] = r1;
    rs = mk_res(32'h0, 1'b1, 1'b0);
    s_res = rs;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      if ((k % 2) == 0) begin
        chk("t2_grant_m0", 128'(grant_idx), 128'(0));
        chk("t2_sreq_m0", 128'(s_req), 128'(r0));
        chk("t2_mres0", 128'(m_res[0]), 128'(rs));
        chk("t2_mres1_zero", 128'(m_res[1]), 128'(zres));
      end else begin
        chk("t2_grant_m1", 128'(grant_idx), 128'(1));
        chk("t2_sreq_m1", 128'(s_req), 128'(r1));
        chk("t2_mres1", 128'(m_res[1]), 128'(rs));
        chk("t2_mres0_zero", 128'(m_res[0]), 128'(zres));
      end
      step(); #1;
      chk("t2_bubble_state", 128'(dut.state), 128'(IDLE));
      chk("t2_bubble_sreq", 128'(s_req), 128'(zreq));
    end

    // Timeout: slave never ready, m1 pending behind m0
    r0 = mk_req(32'h2000, 32'h0, 1'b0, 1'b1);
    r1 = mk_req(32'h3000, 32'h0, 1'b0, 1'b1);
    m_req[0] = r0;
    m_req[1] = r1;
    rs = mk_res(32'h1234, 1'b0, 1'b0);
    s_res = rs;
    step(); #1;
    chk("t3_grant", 128'(grant_idx), 128'(0));
    for (int j = 0; j < 4; j++) begin
      chk("t3_stall_mres0", 128'(m_res[0]), 128'(rs));
      chk("t3_stall_sreq", 128'(s_req), 128'(r0));
      step(); #1;
    end
    chk("t3_tmo_mres0", 128'(m_res[0]), 128'(mk_res(32'h0, 1'b1, 1'b1)));
    chk("t3_tmo_sreq", 128'(s_req), 128'(zreq));
    chk("t3_tmo_mres1", 128'(m_res[1]), 128'(zres));
    step(); #1;
    chk("t3_idle", 128'(dut.state), 128'(IDLE));
    chk("t3_rr_ptr", 128'(dut.rr_ptr), 128'(1));
    step(); #1;
    chk("t3_next_grant", 128'(grant_idx), 128'(1));
    chk("t3_next_sreq", 128'(s_req), 128'(r1));

    // Abort: m1 drops its read after one BUSY cycle
    m_req[0] = '0;
    #1;
    chk("t4_busy_mres1", 128'(m_res[1]), 128'(rs));
    step();
    m_req[1] = '0;
    #1;
    chk("t4_abort_mres1", 128'(m_res[1]), 128'(zres));
    chk("t4_abort_mres0", 128'(m_res[0]), 128'(zres));
    chk("t4_abort_sreq", 128'(s_req), 128'(zreq));
    step(); #1;
    chk("t4_idle", 128'(dut.state), 128'(IDLE));
    chk("t4_rr_ptr", 128'(dut.rr_ptr), 128'(0));

    // Ready arrives in the same cycle the counter reaches the limit
    r0 = mk_req(32'h4000, 32'h0, 1'b0, 1'b1);
    m_req[0] = r0;
    s_res = '0;
    step();
    repeat (4) step();
    rs = mk_res(32'h55, 1'b1, 1'b0);
    s_res = rs;
    #1;
    chk("t5_cnt", 128'(dut.tmo_cnt), 128'(4));
    chk("t5_mres0", 128'(m_res[0]), 128'(rs));
    chk("t5_sreq", 128'(s_req), 128'(r0));
    step(); #1;
    chk("t5_idle", 128'(dut.state), 128'(IDLE));

    // Reset while BUSY with a stalling slave; m1 waits behind m0
    r0 = mk_req(32'h5000, 32'h0, 1'b0, 1'b1);
    r1 = mk_req(32'h6000, 32'h0, 1'b0, 1'b1);
    m_req[0] = r0;
    rs = mk_res(32'h99, 1'b0, 1'b0);
    s_res = rs;
    step(); #1;
    chk("t6_single_grant", 128'(grant_idx), 128'(0));
    chk("t6_sreq_m0", 128'(s_req), 128'(r0));
    m_req[1] = r1;
    step();
    rst = 1'b1;
    m_req[0] = '0;
    #1;
    chk("t6_rst_sreq", 128'(s_req), 128'(zreq));
    chk("t6_rst_mres0", 128'(m_res[0]), 128'(zres));
    chk("t6_rst_mres1", 128'(m_res[1]), 128'(zres));
    chk("t6_rst_state", 128'(dut.state), 128'(IDLE));
    step();
    rst = 1'b0;
    #1;
    chk("t6_rel_idle", 128'(dut.state), 128'(IDLE));
    step(); #1;
    chk("t6_rel_grant", 128'(grant_idx), 128'(1));
    chk("t6_rel_sreq", 128'(s_req), 128'(r1));
    chk("t6_rel_mres1", 128'(m_res[1]), 128'(rs));

    m_req[1] = '0;
    s_res = '0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/minibus_arbiter.md
MINIBUS_ARBITER -- requirements
Module: minibus_arbiter

Interface
REQ-001 SHALL have parameter MASTER_COUNT, default 2, number of upstream minibus masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited for slave ready before error (1..65535).
REQ-003 SHALL have a single clock and an asynchronous active-high reset; all state resets asynchronously on reset high.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port m_req, input, minibus_req_t[MASTER_COUNT], per-master request {addr 32, wdata 32, wen 1, ren 1, strobe 4}.
REQ-007 SHALL have port m_res, output, minibus_res_t[MASTER_COUNT], per-master response {rdata 32, ready 1, error 1}.
REQ-008 SHALL have port s_req, output, minibus_req_t, request driven into the minibus decoder's master side.
REQ-009 SHALL have port s_res, input, minibus_res_t, response returned by the decoder.
REQ-010 SHALL have port grant_idx, output, $clog2(MASTER_COUNT), index of the current owner; debug only.

Function
REQ-011 A master request SHALL be valid when wen or ren is 1; wen and ren both 1 is treated as a write.
REQ-012 FSM SHALL have states IDLE and BUSY.
REQ-013 IDLE: s_req SHALL be all-zero; with any valid request, latch winner into grant_idx, clear timeout counter, go to BUSY next edge (1 arbitration cycle).
REQ-014 Winner SHALL be round-robin: first valid master at or after rr_ptr, wrapping from MASTER_COUNT-1 to 0.
REQ-015 BUSY: s_req SHALL combinationally equal m_req[grant_idx]; m_res[grant_idx] SHALL combinationally equal s_res.
REQ-016 Non-granted masters SHALL see m_res all-zero (ready 0, stall) in every state.
REQ-017 BUSY with s_res.ready=1: transfer completes this cycle; rr_ptr SHALL become grant_idx+1 (mod MASTER_COUNT); next state IDLE.
REQ-018 BUSY with s_res.ready=0: timeout counter increments, saturating at TIMEOUT_CYCLES.
REQ-019 When counter equals TIMEOUT_CYCLES and ready=0, m_res[grant_idx] SHALL be {rdata 0, ready 1, error 1} for that cycle only, s_req SHALL be zero that cycle, rr_ptr advances as in REQ-017, next state IDLE.
REQ-020 s_res.ready and timeout in the same cycle: ready wins; slave response forwarded, error 0.
REQ-021 Granted master dropping wen and ren in BUSY: abort; no response, s_req zero, rr_ptr advances, next state IDLE.
REQ-022 Worst-case latency per request, uncontended: 1 arbitration cycle + slave wait cycles; back-to-back transfers have a 1-cycle IDLE bubble.
REQ-023 Single requester SHALL be granted regardless of rr_ptr.

Reset
REQ-024 On rst: state IDLE, grant_idx 0, rr_ptr 0, counter 0, s_req all-zero, every m_res all-zero.
REQ-025 Reset asserted mid-BUSY SHALL abort immediately with no response to the granted master; the slave sees s_req zero from reset assertion.
REQ-026 First arbitration after reset release occurs at the first rising edge with rst low.

Structure
REQ-027 minibus_req_t, minibus_res_t and the FSM state enum SHALL live in minibus_pkg.
REQ-028 Round-robin winner selection SHALL be a combinational sub-module, minibus_rr_select (inputs valid vector and rr_ptr, outputs index and any_valid).
REQ-029 Exactly one flop set each for state, grant_idx, rr_ptr and counter; no buffering of request data.

Verification
REQ-030 Single master: m0 ren addr 0x1000, slave ready after 2 wait cycles with rdata 0xDEADBEEF -> m0 sees ready=1, rdata 0xDEADBEEF in cycle 4 after request; m1 res zero throughout.
REQ-031 Contention: m0 and m1 write continuously from reset, ready immediate -> grants alternate 0,1,0,1; each grant lasts 1 BUSY cycle.
REQ-032 Timeout: TIMEOUT_CYCLES=4, slave never ready -> m0 gets ready=1 error=1 exactly 5 cycles after entering BUSY; next grant then goes to m1 if pending.
REQ-033 Ready and timeout coincide at count 4, rdata 0x55 -> m0 gets rdata 0x55, error 0.
REQ-034 Abort: m1 granted, drops ren after 1 BUSY cycle -> no response, FSM IDLE next edge, rr_ptr=0.
REQ-035 Reset mid-BUSY with slave stalling -> s_req and all m_res zero immediately; after release, pending m1 request is granted first (rr_ptr 0, m0 idle).
